reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_sequencer.sv | 177 +++++++++++++++++
 tb/tb_reset_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Holds a set of clock domains in reset for a fixed number of enabled cycles, then walks
//   through them one at a time with an init strobe, waiting for each domain's acknowledge
//   (or a timeout) before moving to the next. Once every domain has been visited the block
//   enables the domains that answered and idles in RUN until the next reset request.
//
// Ports
//   clk          clock, all logic on the rising edge
//   sync_rst     synchronous active-high reset, overrides everything including clk_en
//   clk_en       global enable; when low every register holds and inputs are ignored
//   ResetReq     reset requesters: [0] external pin, [1] watchdog, [2] software
//   DomainAck    per-domain init-complete acknowledge (level)
//   DomainRst    per-domain reset request
//   DomainInit   per-domain init strobe, held until ack or timeout
//   DomainEn     per-domain operational enable
//   Busy         high whenever the sequencer is not in RUN
//   LastCause    0/1/2 = winning ResetReq bit, 3 = power-on (sync_rst)
//   DomainFault  sticky per-domain ack-timeout flags, cleared only by sync_rst
module reset_sequencer #(
    parameter int unsigned DOMAINS         = 2,
    parameter int unsigned RESETWAITCYCLES = 6,
    parameter int unsigned ACKTIMEOUT      = 32
) (
    input  logic               clk,
    input  logic               sync_rst,
    input  logic               clk_en,
    input  logic [2:0]         ResetReq,
    input  logic [DOMAINS-1:0] DomainAck,
    output logic [DOMAINS-1:0] DomainRst,
    output logic [DOMAINS-1:0] DomainInit,
    output logic [DOMAINS-1:0] DomainEn,
    output logic               Busy,
    output logic [1:0]         LastCause,
    output logic [DOMAINS-1:0] DomainFault
);

    localparam int unsigned HoldW = $clog2(RESETWAITCYCLES) + 1;
    localparam int unsigned TmoW  = $clog2(ACKTIMEOUT) + 1;
    localparam int unsigned IdxW  = $clog2(DOMAINS) + 1;

    localparam logic [HoldW-1:0] HoldLast = HoldW'(RESETWAITCYCLES - 1);
    localparam logic [TmoW-1:0]  TmoLast  = TmoW'(ACKTIMEOUT - 1);
    localparam logic [IdxW-1:0]  IdxLast  = IdxW'(DOMAINS - 1);

    typedef enum logic [1:0] {
        StRstHold,
        StInitSeq,
        StRun
    } state_e;

    state_e               state_q, state_d;
    logic [HoldW-1:0]     hold_cnt_q, hold_cnt_d;
    logic [TmoW-1:0]      tmo_cnt_q, tmo_cnt_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic [DOMAINS-1:0]   rst_q, rst_d;
    logic [DOMAINS-1:0]   init_q, init_d;
    logic [DOMAINS-1:0]   en_q, en_d;
    logic                 busy_q, busy_d;
    logic [1:0]           cause_q, cause_d;
    logic [DOMAINS-1:0]   fault_q, fault_d;

    logic                 ack_sel;
    logic                 slot_done;
    logic [DOMAINS-1:0]   fault_next;

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        idx_d      = idx_q;
        rst_d      = rst_q;
        init_d     = init_q;
        en_d       = en_q;
        busy_d     = busy_q;
        cause_d    = cause_q;
        fault_d    = fault_q;

        // init_q is one-hot on the active domain during INIT_SEQ and zero elsewhere, so it
        // doubles as the ack select mask and as the fault bit to set on timeout.
        ack_sel    = |(DomainAck & init_q);
        slot_done  = ack_sel || (tmo_cnt_q == TmoLast);
        fault_next = ack_sel ? fault_q : (fault_q | init_q);

        if (clk_en) begin
            if (|ResetReq) begin
                // A request restarts from scratch in every state, including mid-hold.
                state_d    = StRstHold;
                hold_cnt_d = '0;
                tmo_cnt_d  = '0;
                idx_d      = '0;
                rst_d      = '1;
                init_d     = '0;
                en_d       = '0;
                busy_d     = 1'b1;
                if (ResetReq[0]) begin
                    cause_d = 2'd0;
                end else if (ResetReq[1]) begin
                    cause_d = 2'd1;
                end else begin
                    cause_d = 2'd2;
                end
            end else begin
                unique case (state_q)
                    StRstHold: begin
                        if (hold_cnt_q == HoldLast) begin
                            state_d   = StInitSeq;
                            rst_d     = '0;
                            idx_d     = '0;
                            init_d    = DOMAINS'(1);
                            tmo_cnt_d = '0;
                        end else begin
                            hold_cnt_d = hold_cnt_q + HoldW'(1);
                        end
                    end
                    StInitSeq: begin
                        if (slot_done) begin
                            fault_d   = fault_next;
                            tmo_cnt_d = '0;
                            if (idx_q == IdxLast) begin
                                state_d = StRun;
                                idx_d   = '0;
                                init_d  = '0;
                                en_d    = ~fault_next;
                                busy_d  = 1'b0;
                            end else begin
                                // Next domain's strobe rises on the same edge: no gap cycle.
                                idx_d  = idx_q + IdxW'(1);
                                init_d = init_q << 1;
                            end
                        end else begin
                            tmo_cnt_d = tmo_cnt_q + TmoW'(1);
                        end
                    end
                    StRun: begin
                    end
                    default: begin
                        state_d = StRstHold;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_q    <= StRstHold;
            hold_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            idx_q      <= '0;
            rst_q      <= '1;
            init_q     <= '0;
            en_q       <= '0;
            busy_q     <= 1'b1;
            cause_q    <= 2'd3;
            fault_q    <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            idx_q      <= idx_d;
            rst_q      <= rst_d;
            init_q     <= init_d;
            en_q       <= en_d;
            busy_q     <= busy_d;
            cause_q    <= cause_d;
            fault_q    <= fault_d;
        end
    end

    assign DomainRst   = rst_q;
    assign DomainInit  = init_q;
    assign DomainEn    = en_q;
    assign Busy        = busy_q;
    assign LastCause   = cause_q;
    assign DomainFault = fault_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer with DOMAINS=2, RESETWAITCYCLES=6, ACKTIMEOUT=32.
module tb_reset_sequencer;

    localparam int D   = 2;
    localparam int RWC = 6;
    localparam int AT  = 32;
    localparam int ALL = (1 << D) - 1;

    logic         clk = 1'b0;
    logic         sync_rst;
    logic         clk_en;
    logic [2:0]   ResetReq;
    logic [D-1:0] DomainAck;
    logic [D-1:0] DomainRst;
    logic [D-1:0] DomainInit;
    logic [D-1:0] DomainEn;
    logic         Busy;
    logic [1:0]   LastCause;
    logic [D-1:0] DomainFault;

    int checks = 0;
    int errors = 0;

    reset_sequencer #(
        .DOMAINS        (D),
        .RESETWAITCYCLES(RWC),
        .ACKTIMEOUT     (AT)
    ) dut (
        .clk        (clk),
        .sync_rst   (sync_rst),
        .clk_en     (clk_en),
        .ResetReq   (ResetReq),
        .DomainAck  (DomainAck),
        .DomainRst  (DomainRst),
        .DomainInit (DomainInit),
        .DomainEn   (DomainEn),
        .Busy       (Busy),
        .LastCause  (LastCause),
        .DomainFault(DomainFault)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Ack responder: mode 0 never acks, 1 acks in the 3rd cycle of the strobe, 2 always high.
    int ack_mode[D] = '{1, 1};
    int hi_cnt[D]   = '{0, 0};

    always @(negedge clk) begin
        for (int d = 0; d < D; d++) begin
            if (DomainInit[d] === 1'b1) hi_cnt[d]++;
            else hi_cnt[d] = 0;
            case (ack_mode[d])
                2:       DomainAck[d] = 1'b1;
                1:       DomainAck[d] = (hi_cnt[d] >= 3);
                default: DomainAck[d] = 1'b0;
            endcase
        end
    end

    // Model: m_age counts enabled quiet cycles since the last reset event. The first RWC of
    // them are the hold; after that domains are visited in order, each slot lasting until
    // ack or AT cycles, with m_slot the age at which the current slot opened.
    bit           m_live = 1'b0;
    int           m_age, m_dom, m_slot, m_cause;
    logic [D-1:0] m_fault;

    always @(posedge clk) begin
        if (sync_rst) begin
            m_live  = 1'b1;
            m_age   = 0;
            m_dom   = 0;
            m_slot  = 0;
            m_cause = 3;
            m_fault = '0;
        end else if (m_live && clk_en) begin
            if (ResetReq != 3'b000) begin
                m_age   = 0;
                m_dom   = 0;
                m_cause = ResetReq[0] ? 0 : (ResetReq[1] ? 1 : 2);
            end else if (m_age < RWC) begin
                m_age++;
                m_slot = m_age;
            end else if (m_dom < D) begin
                if (DomainAck[m_dom] === 1'b1) begin
                    m_dom++;
                    m_slot = m_age + 1;
                end else if (m_age - m_slot + 1 == AT) begin
                    m_fault[m_dom] = 1'b1;
                    m_dom++;
                    m_slot = m_age + 1;
                end
                m_age++;
            end
        end
    end

    always @(negedge clk) begin : cmp
        logic [D-1:0] e_rst, e_init, e_en;
        logic         e_run;
        if (m_live) begin
            e_run  = (m_age >= RWC) && (m_dom == D);
            e_rst  = (m_age < RWC) ? '1 : '0;
            e_init = '0;
            if (m_age >= RWC && m_dom < D) e_init[m_dom] = 1'b1;
            e_en   = e_run ? ~m_fault : '0;
            check("cyc DomainRst",   8'(DomainRst),   8'(e_rst));
            check("cyc DomainInit",  8'(DomainInit),  8'(e_init));
            check("cyc DomainEn",    8'(DomainEn),    8'(e_en));
            check("cyc Busy",        8'(Busy),        8'(!e_run));
            check("cyc LastCause",   8'(LastCause),   8'(m_cause));
            check("cyc DomainFault", 8'(DomainFault), 8'(m_fault));
        end
    end

    task automatic wait_run(input string name);
        int k = 0;
        while (Busy !== 1'b0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        check(name, 8'(Busy), 8'(0));
    endtask

    task automatic pulse_req(input logic [2:0] v);
        ResetReq = v;
        @(negedge clk);
        ResetReq = 3'b000;
    endtask

    task automatic obs_step(inout int n);
        if (DomainRst === 2'(ALL)) n++;
        @(negedge clk);
    endtask

    initial begin
        int n;
        int k;
        sync_rst = 1'b1;
        clk_en   = 1'b1;
        ResetReq = 3'b000;
        repeat (2) @(negedge clk);

        // Power-on
        check("por DomainRst",   8'(DomainRst),   8'(3));
        check("por DomainInit",  8'(DomainInit),  8'(0));
        check("por DomainEn",    8'(DomainEn),    8'(0));
        check("por Busy",        8'(Busy),        8'(1));
        check("por LastCause",   8'(LastCause),   8'(3));
        check("por DomainFault", 8'(DomainFault), 8'(0));
        sync_rst = 1'b0;
        repeat (11) @(negedge clk);
        check("po busy before run", 8'(Busy), 8'(1));
        check("po second slot", 8'(DomainInit), 8'(2));
        @(negedge clk);
        check("po busy", 8'(Busy), 8'(0));
        check("po en", 8'(DomainEn), 8'(3));
        check("po cause", 8'(LastCause), 8'(3));
        repeat (2) @(negedge clk);

        // Arbitration
        pulse_req(3'b110);
        check("arb cause", 8'(LastCause), 8'(1));
        check("arb en", 8'(DomainEn), 8'(0));
        check("arb rst", 8'(DomainRst), 8'(3));
        wait_run("arb run");
        check("arb en run", 8'(DomainEn), 8'(3));

        // Timeout on domain 1
        ack_mode[1] = 0;
        @(negedge clk);
        pulse_req(3'b100);
        n = 0;
        k = 0;
        while (Busy !== 1'b0 && k < 300) begin
            if (DomainInit[1] === 1'b1) n++;
            @(negedge clk);
            k++;
        end
        check("tmo init1 cycles", 8'(n), 8'(32));
        check("tmo fault", 8'(DomainFault), 8'(2));
        check("tmo en", 8'(DomainEn), 8'(1));
        check("tmo cause", 8'(LastCause), 8'(2));
        ack_mode[1] = 1;
        @(negedge clk);
        pulse_req(3'b100);
        wait_run("tmo2 run");
        check("tmo2 fault sticky", 8'(DomainFault), 8'(2));
        check("tmo2 en", 8'(DomainEn), 8'(1));

        // Abort mid-init
        pulse_req(3'b010);
        k = 0;
        while (DomainInit !== 2'b10 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("abort reached d1", 8'(DomainInit), 8'(2));
        pulse_req(3'b001);
        check("abort init", 8'(DomainInit), 8'(0));
        check("abort rst", 8'(DomainRst), 8'(3));
        check("abort cause", 8'(LastCause), 8'(0));
        n = 0;
        while (DomainRst === 2'(ALL) && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("abort hold", 8'(n), 8'(6));
        check("abort restart d0", 8'(DomainInit), 8'(1));
        wait_run("abort run");

        // Stall inside the hold, request inside the gap
        ResetReq = 3'b100;
        @(negedge clk);
        ResetReq = 3'b000;
        n = 0;
        obs_step(n);
        obs_step(n);
        clk_en = 1'b0;
        obs_step(n);
        obs_step(n);
        ResetReq = 3'b001;
        obs_step(n);
        ResetReq = 3'b000;
        obs_step(n);
        obs_step(n);
        clk_en = 1'b1;
        while (DomainRst === 2'(ALL) && n < 50) obs_step(n);
        check("stall hold total", 8'(n), 8'(11));
        check("stall cause", 8'(LastCause), 8'(2));
        wait_run("stall run");

        // Fault on domain 0, then sync_rst in RUN
        sync_rst    = 1'b1;
        ack_mode[0] = 0;
        @(negedge clk);
        sync_rst = 1'b0;
        wait_run("f01 run");
        check("f01 fault", 8'(DomainFault), 8'(1));
        check("f01 en", 8'(DomainEn), 8'(2));
        sync_rst    = 1'b1;
        ack_mode[0] = 1;
        @(negedge clk);
        sync_rst = 1'b0;
        check("midrun fault", 8'(DomainFault), 8'(0));
        check("midrun en", 8'(DomainEn), 8'(0));
        check("midrun rst", 8'(DomainRst), 8'(3));
        check("midrun cause", 8'(LastCause), 8'(3));
        check("midrun busy", 8'(Busy), 8'(1));
        wait_run("midrun run");

        // Request held high
        ResetReq = 3'b100;
        repeat (20) @(negedge clk);
        check("held rst", 8'(DomainRst), 8'(3));
        ResetReq = 3'b000;
        n = 0;
        while (DomainRst === 2'(ALL) && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("held release", 8'(n), 8'(6));
        wait_run("held run");

        // sync_rst with clk_en low mid-init
        pulse_req(3'b001);
        k = 0;
        while (DomainInit !== 2'b01 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("gate reached d0", 8'(DomainInit), 8'(1));
        clk_en   = 1'b0;
        sync_rst = 1'b1;
        @(negedge clk);
        check("gate rst", 8'(DomainRst), 8'(3));
        check("gate init", 8'(DomainInit), 8'(0));
        check("gate cause", 8'(LastCause), 8'(3));
        sync_rst = 1'b0;
        clk_en   = 1'b1;

        // Acks already high on slot entry
        ack_mode[0] = 2;
        ack_mode[1] = 2;
        n = 0;
        k = 0;
        while (Busy !== 1'b0 && k < 300) begin
            if (DomainInit !== 2'b00) n++;
            @(negedge clk);
            k++;
        end
        check("preack init cycles", 8'(n), 8'(2));
        check("preack en", 8'(DomainEn), 8'(3));
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
